// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: each FIFO word goes out as 0xA5, payload bytes, XOR checksum.
// Define UART_FRAME_TX_PARITY_EN to add an even-parity bit to every character (8E1).
module uart_frame_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [2:0]            baud_set,
  output logic                  uart_tx,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BYTE_CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int DIV_W      = $clog2(CLK_FREQ / 9600 + 1);
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif

  localparam logic [3:0]            STOP_BIT  = 4'(STOP_IDX);
  localparam logic [PTR_W:0]        PTR_ONE   = 1;
  localparam logic [DIV_W-1:0]      DIV_ONE   = 1;
  localparam logic [BYTE_CNT_W-1:0] BYTE_ONE  = 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SYNC, DATA, CHK} state_t;

  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    return DIV_W'(CLK_FREQ / 9600);
      3'd1:    return DIV_W'(CLK_FREQ / 19200);
      3'd2:    return DIV_W'(CLK_FREQ / 38400);
      3'd3:    return DIV_W'(CLK_FREQ / 57600);
      3'd4:    return DIV_W'(CLK_FREQ / 115200);
      3'd5:    return DIV_W'(CLK_FREQ / 230400);
      3'd6:    return DIV_W'(CLK_FREQ / 460800);
      default: return DIV_W'(CLK_FREQ / 921600);
    endcase
  endfunction

  // Line level for bit position idx of a character: start, data LSB first, [parity], stop.
  function automatic logic line_bit(input logic [3:0] idx, input logic [7:0] b);
    if (idx == 4'd0) return 1'b0;
    if (idx <= 4'd8) return b[idx[2:0] - 3'd1];
`ifdef UART_FRAME_TX_PARITY_EN
    if (idx == 4'd9) return ^b;
`endif
    return 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty, fifo_full, push;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d, baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d, byte_sel;
  logic [DATA_WIDTH-1:0] word_q, word_d, word_shifted;
  logic                  tx_q, tx_d, frame_done_q, frame_done_d;
  logic [7:0]            chk_byte, cur_byte;

  // Pointers carry a wrap bit so equal low bits distinguish full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = data_valid && !fifo_full;
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= data;
  end

  always_comb begin
    chk_byte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) chk_byte = chk_byte ^ word_q[i*8 +: 8];
  end

  assign byte_sel     = (MSB_FIRST != 0) ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;
  assign word_shifted = word_q >> {byte_sel, 3'b000};

  always_comb begin
    case (state_q)
      DATA:    cur_byte = word_shifted[7:0];
      CHK:     cur_byte = chk_byte;
      default: cur_byte = 8'hA5;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    div_d        = div_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = LOAD;
          word_d   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          div_d    = baud_div(baud_set);
        end
      end
      LOAD: begin
        state_d    = SYNC;
        bit_idx_d  = 4'd0;
        baud_cnt_d = div_q - DIV_ONE;
        tx_d       = 1'b0;
      end
      default: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - DIV_ONE;
        end else if (bit_idx_q != STOP_BIT) begin
          bit_idx_d  = bit_idx_q + 4'd1;
          baud_cnt_d = div_q - DIV_ONE;
          tx_d       = line_bit(bit_idx_q + 4'd1, cur_byte);
        end else begin
          // Character complete: the next start bit begins on the following cycle.
          bit_idx_d  = 4'd0;
          baud_cnt_d = div_q - DIV_ONE;
          tx_d       = 1'b0;
          case (state_q)
            SYNC: begin
              state_d    = DATA;
              byte_cnt_d = '0;
            end
            DATA: begin
              if (byte_cnt_q == LAST_BYTE) state_d = CHK;
              else byte_cnt_d = byte_cnt_q + BYTE_ONE;
            end
            CHK: begin
              frame_done_d = 1'b1;
              if (!fifo_empty) begin
                state_d    = SYNC;
                word_d     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                div_d      = baud_div(baud_set);
                baud_cnt_d = baud_div(baud_set) - DIV_ONE;
              end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      div_q        <= '0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= 4'd0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      div_q        <= div_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_ready = !fifo_full;
  assign uart_tx    = tx_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected characters are queued when words are pushed
// and a line monitor checks every cycle of each character plus the frame_done position.
module tb_uart_frame_tx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int DIV0 = 5208;
  localparam int DIV4 = 434;
  localparam int DIV7 = 54;
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int CHAR_BITS = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int CHAR_BITS = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    int         div;
    bit         last;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] data;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [2:0]  baud_set;
  logic        tx0, tx1, fd0, fd1, busy0, busy1;
  logic        mtx, mfd, mbusy;
  bit          mon_sel;
  bit          mon_en;
  exp_t        sb[$];
  int          checks;
  int          errors;
  int          fd_count;

  uart_frame_tx #(.DATA_WIDTH(32), .MSB_FIRST(0), .FIFO_DEPTH(4), .CLK_FREQ(CLK_FREQ)) dut0 (
    .clk(clk), .reset_n(reset_n), .data(data), .data_valid(valid0), .data_ready(ready0),
    .baud_set(baud_set), .uart_tx(tx0), .frame_done(fd0), .busy(busy0)
  );

  uart_frame_tx #(.DATA_WIDTH(32), .MSB_FIRST(1), .FIFO_DEPTH(4), .CLK_FREQ(CLK_FREQ)) dut1 (
    .clk(clk), .reset_n(reset_n), .data(data), .data_valid(valid1), .data_ready(ready1),
    .baud_set(baud_set), .uart_tx(tx1), .frame_done(fd1), .busy(busy1)
  );

  assign mtx   = mon_sel ? tx1 : tx0;
  assign mfd   = mon_sel ? fd1 : fd0;
  assign mbusy = mon_sel ? busy1 : busy0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR_EN && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Expected characters of one frame, built from the word and byte order.
  task automatic push_frame(input logic [31:0] w, input bit msb, input int div);
    logic [7:0] c;
    logic [7:0] byt;
    int k;
    c = 8'h00;
    sb.push_back('{b: 8'hA5, div: div, last: 1'b0});
    for (int i = 0; i < 4; i++) begin
      k = msb ? 3 - i : i;
      byt = w[k*8 +: 8];
      c = c ^ byt;
      sb.push_back('{b: byt, div: div, last: 1'b0});
    end
    sb.push_back('{b: c, div: div, last: 1'b1});
  endtask

  task automatic send_word(input bit which, input logic [31:0] w);
    @(posedge clk); #1;
    data = w;
    if (which) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || mbusy !== 1'b0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || mbusy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: %0d chars pending busy=%b after %0d cycles, required 0 pending and idle",
               tag, sb.size(), mbusy, n);
    end
  endtask

  initial begin : fd_counter
    fd_count = 0;
    forever begin
      @(negedge clk);
      if (reset_n && mfd === 1'b1) fd_count++;
    end
  end

  // Line monitor: compares every cycle of each character against the queued byte.
  initial begin : monitor
    exp_t e;
    bit   bad, aborted, skip_wait;
    int   bad_n;
    logic bad_v, want;
    skip_wait = 1'b0;
    forever begin
      if (!skip_wait) @(negedge clk);
      skip_wait = 1'b0;
      if (reset_n && mon_en && mtx === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: start bit seen with no character expected");
          repeat (CHAR_BITS * DIV7) @(negedge clk);
        end else begin
          e = sb.pop_front();
          bad = 1'b0;
          aborted = 1'b0;
          bad_n = 0;
          bad_v = 1'b0;
          for (int n = 0; n < CHAR_BITS * e.div; n++) begin
            if (n > 0) @(negedge clk);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            want = exp_bit(e.b, n / e.div);
            if (mtx !== want && !bad) begin
              bad = 1'b1;
              bad_n = n;
              bad_v = mtx;
            end
          end
          if (!aborted) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL char_%02h: line=%b at cycle %0d of character, required %b (div %0d)",
                       e.b, bad_v, bad_n, exp_bit(e.b, bad_n / e.div), e.div);
            end else begin
              $display("char %02h ok (div %0d%s)", e.b, e.div, e.last ? ", checksum" : "");
            end
            if (e.last) begin
              @(negedge clk);
              checks++;
              if (mfd !== 1'b1) begin
                errors++;
                $display("FAIL frame_done_pos: frame_done=%b after checksum stop bit, required 1", mfd);
              end
              skip_wait = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx0 !== 1'b1)    begin errors++; $display("FAIL reset_tx: uart_tx=%b, required 1", tx0); end
    if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: data_ready=%b, required 1", ready0); end
    if (fd0 !== 1'b0)    begin errors++; $display("FAIL reset_frame_done: frame_done=%b, required 0", fd0); end
    if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: busy=%b, required 0", busy0); end
    if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset_tx_msb: uart_tx=%b, required 1", tx1); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_basic();
    int n, fd_base;
    mon_sel = 1'b0;
    baud_set = 3'd4;
    fd_base = fd_count;
    push_frame(32'h12345678, 1'b0, DIV4);
    send_word(1'b0, 32'h12345678);
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL latency_1: uart_tx=%b one cycle after accept, required 1", tx0); end
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL latency_2: uart_tx=%b two cycles after accept, required 1", tx0); end
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL latency_3: uart_tx=%b after 2nd edge, required 0", tx0); end
    n = 0;
    while (fd0 !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (n != 6 * CHAR_BITS * DIV4) begin
      errors++;
      $display("FAIL frame_length: %0d cycles start to frame_done, required %0d", n, 6 * CHAR_BITS * DIV4);
    end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_fall: busy=%b on frame_done cycle, required 0", busy0); end
    wait_done(100, "basic");
    repeat (5) @(negedge clk);
    checks++;
    if (fd_count - fd_base != 1) begin
      errors++;
      $display("FAIL basic_fd_count: %0d frame_done pulses, required 1", fd_count - fd_base);
    end
    $display("basic frame 12345678 done");
  endtask

  task automatic test_byte_order();
    int fd_base;
    mon_sel = 1'b1;
    baud_set = 3'd7;
    fd_base = fd_count;
    push_frame(32'h87654321, 1'b1, DIV7);
    send_word(1'b1, 32'h87654321);
    wait_done(6 * CHAR_BITS * DIV7 + 50, "byte_order");
    repeat (5) @(negedge clk);
    checks++;
    if (fd_count - fd_base != 1) begin
      errors++;
      $display("FAIL order_fd_count: %0d frame_done pulses, required 1", fd_count - fd_base);
    end
    mon_sel = 1'b0;
    $display("byte order frame 87654321 done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6];
    logic exp_rdy;
    bit started;
    int n, frames, fd_base;
    words[0] = 32'h01020304; words[1] = 32'hDEADBEEF; words[2] = 32'h00FF00FF;
    words[3] = 32'hCAFEF00D; words[4] = 32'h13579BDF; words[5] = 32'hBAD0BAD0;
    mon_sel = 1'b0;
    baud_set = 3'd7;
    fd_base = fd_count;
    started = 1'b0;
    n = 0;
    frames = 0;
    for (int k = 0; k < 20000 && frames < 5; k++) begin
      @(posedge clk); #1;
      if (k < 6) begin
        data = words[k];
        valid0 = 1'b1;
      end else begin
        valid0 = 1'b0;
      end
      @(negedge clk);
      if (k < 6) begin
        exp_rdy = (k < 5);
        checks++;
        if (ready0 !== exp_rdy) begin
          errors++;
          $display("FAIL ready_%0d: data_ready=%b on push cycle %0d, required %b", k, ready0, k, exp_rdy);
        end
        if (k < 5) push_frame(words[k], 1'b0, DIV7);
      end
      if (started) begin
        n++;
        if (fd0 === 1'b1) frames++;
      end else if (tx0 === 1'b0) begin
        started = 1'b1;
      end
    end
    valid0 = 1'b0;
    checks++;
    if (frames != 5 || n != 5 * 6 * CHAR_BITS * DIV7) begin
      errors++;
      $display("FAIL gapless: %0d frames in %0d cycles, required 5 frames in %0d", frames, n,
               5 * 6 * CHAR_BITS * DIV7);
    end
    wait_done(6 * CHAR_BITS * DIV7, "back_to_back");
    repeat (CHAR_BITS * DIV7) @(negedge clk);
    checks++;
    if (fd_count - fd_base != 5 || tx0 !== 1'b1) begin
      errors++;
      $display("FAIL dropped_word: %0d frames, uart_tx=%b, required 5 frames and idle line",
               fd_count - fd_base, tx0);
    end
    $display("back-to-back 5 frames done");
  endtask

  task automatic test_baud_latch();
    int n;
    mon_sel = 1'b0;
    baud_set = 3'd7;
    push_frame(32'hA1B2C3D4, 1'b0, DIV7);
    send_word(1'b0, 32'hA1B2C3D4);
    repeat (1000) @(negedge clk);
    baud_set = 3'd0;
    wait_done(6 * CHAR_BITS * DIV7, "baud_latch");
    mon_en = 1'b0;
    send_word(1'b0, 32'h55AA55AA);
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx0 === 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != DIV0) begin
      errors++;
      $display("FAIL next_frame_baud: start bit %0d cycles, required %0d", n, DIV0);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    baud_set = 3'd7;
    @(negedge clk);
    mon_en = 1'b1;
    $display("baud latch done");
  endtask

  task automatic test_reset_mid();
    int fd_base;
    bit stayed_idle;
    mon_sel = 1'b0;
    mon_en = 1'b0;
    baud_set = 3'd7;
    send_word(1'b0, 32'h11223344);
    send_word(1'b0, 32'h55667788);
    repeat (2 + CHAR_BITS * DIV7 + 100) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (tx0 !== 1'b1)    begin errors++; $display("FAIL mid_reset_tx: uart_tx=%b in reset cycle, required 1", tx0); end
    if (busy0 !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy: busy=%b, required 0", busy0); end
    if (ready0 !== 1'b1) begin errors++; $display("FAIL mid_reset_fifo: data_ready=%b, required 1", ready0); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    fd_base = fd_count;
    push_frame(32'h24680135, 1'b0, DIV7);
    send_word(1'b0, 32'h24680135);
    wait_done(6 * CHAR_BITS * DIV7 + 50, "reset_mid");
    stayed_idle = 1'b1;
    repeat (CHAR_BITS * DIV7 * 2) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle || fd_count - fd_base != 1) begin
      errors++;
      $display("FAIL no_retransmit: idle=%b frames=%0d, required idle line and 1 frame",
               stayed_idle, fd_count - fd_base);
    end
    $display("reset mid-frame done");
  endtask

`ifdef UART_FRAME_TX_PARITY_EN
  task automatic test_parity();
    int n;
    mon_sel = 1'b0;
    baud_set = 3'd7;
    push_frame(32'h000000FF, 1'b0, DIV7);
    send_word(1'b0, 32'h000000FF);
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (fd0 !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 6 * 11 * DIV7) begin
      errors++;
      $display("FAIL parity_length: %0d cycles per frame, required %0d", n, 6 * 11 * DIV7);
    end
    wait_done(100, "parity");
    $display("parity frame done");
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    data = 32'h0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    baud_set = 3'd4;
    mon_sel = 1'b0;
    mon_en = 1'b1;
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_byte_order();
    test_back_to_back();
    test_baud_latch();
    test_reset_mid();
`ifdef UART_FRAME_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
